// File: rtl/imem_access_arbiter.sv
// Arbitrates the single-port instruction memory between IF fetches and a program loader (BOOT fill, RUN patching).
// Optional build macro IMEM_WRITE_PROTECT_EN: memory becomes read-only once the core leaves BOOT.
module imem_access_arbiter #(
  parameter int SIZE     = 64,
  parameter int MAX_WAIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fetch_address,
  input  logic        fetch_hold,
  output logic [31:0] fetch_instruction,
  output logic        fetch_stall,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_address,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic        load_error,
  output logic [7:0]  load_count,
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic [0:0]  dbg_state_o
);

  // Loader handshake: a write is accepted on the rising edge where load_valid && load_ready.
  // load_valid may be held indefinitely; load_ready may depend combinationally on load_valid.

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int          WW         = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX_W = WW'(MAX_WAIT);
  localparam logic [29:0]   SIZE_W     = 30'(SIZE);

  logic [0:0]    state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          load_error_q, load_error_d;
  logic [7:0]    load_count_q, load_count_d;

  logic in_range;
  logic wait_full;
  logic grant_l;
  logic write_ok;
  logic accept;

  // Byte-offset bits are dropped: unaligned writes land on the containing word.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^load_address[1:0];

  always_comb begin
    in_range   = load_address[31:2] < SIZE_W;
    wait_full  = wait_cnt_q == WAIT_MAX_W;
    grant_l    = 1'b1;
    load_ready = 1'b1;
    fetch_stall = 1'b1;
    write_ok   = 1'b1;
    if (state_q == ST_RUN) begin
`ifdef IMEM_WRITE_PROTECT_EN
      load_ready  = load_valid;
      grant_l     = 1'b0;
      fetch_stall = 1'b0;
      write_ok    = 1'b0;
`else
      load_ready  = load_valid && (fetch_hold || wait_full);
      grant_l     = load_ready;
      // A stall-slot write costs nothing; only a forced steal holds the PC.
      fetch_stall = load_ready && !fetch_hold;
`endif
    end
    accept            = load_valid && load_ready;
    mem_address       = grant_l ? load_address : fetch_address;
    mem_write_en      = grant_l && load_valid && in_range && write_ok && !reset;
    mem_write_data    = load_data;
    fetch_instruction = grant_l ? 32'b0 : mem_read_data;
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    load_error_d = load_error_q;
    load_count_d = load_count_q;

    if (state_q == ST_BOOT && load_done) state_d = ST_RUN;

    if (state_q == ST_RUN && load_valid && !load_ready)
      wait_cnt_d = wait_full ? wait_cnt_q : wait_cnt_q + 1'b1;

    if (accept && (!in_range || !write_ok)) load_error_d = 1'b1;

    if (accept && in_range && write_ok && load_count_q != 8'hFF)
      load_count_d = load_count_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      wait_cnt_q   <= '0;
      load_error_q <= 1'b0;
      load_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      load_error_q <= load_error_d;
      load_count_q <= load_count_d;
    end
  end

  assign load_error  = load_error_q;
  assign load_count  = load_count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter with a behavioural 64-word async-read memory attached.
module tb_imem_access_arbiter;

  logic        clock;
  logic        reset;
  logic [31:0] fetch_address;
  logic        fetch_hold;
  logic [31:0] fetch_instruction;
  logic        fetch_stall;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_address;
  logic [31:0] load_data;
  logic        load_done;
  logic        load_error;
  logic [7:0]  load_count;
  logic [31:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [0:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];

  imem_access_arbiter #(.SIZE(64), .MAX_WAIT(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .fetch_address     (fetch_address),
    .fetch_hold        (fetch_hold),
    .fetch_instruction (fetch_instruction),
    .fetch_stall       (fetch_stall),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .load_address      (load_address),
    .load_data         (load_data),
    .load_done         (load_done),
    .load_error        (load_error),
    .load_count        (load_count),
    .mem_address       (mem_address),
    .mem_write_en      (mem_write_en),
    .mem_write_data    (mem_write_data),
    .mem_read_data     (mem_read_data),
    .dbg_state_o       (dbg_state_o)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: async read, write on posedge, out-of-range reads return 0
  always_comb begin
    if (mem_address[31:2] < 30'd64) mem_read_data = mem[mem_address[7:2]];
    else                            mem_read_data = 32'b0;
  end

  always @(posedge clock) begin
    if (mem_write_en && mem_address[31:2] < 30'd64) mem[mem_address[7:2]] <= mem_write_data;
  end

  // Driver / checker tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset = 1'b1; fetch_address = 32'h0; fetch_hold = 1'b0;
    load_valid = 1'b0; load_address = 32'h0; load_data = 32'h0; load_done = 1'b0;
    tick(); tick();

    // Reset state
    reset = 1'b0;
    mid();
    check("rst_state", 32'(dbg_state_o), 32'd0);
    check("rst_stall", 32'(fetch_stall), 32'd1);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_instr", fetch_instruction, 32'h0);
    check("rst_err", 32'(load_error), 32'd0);
    check("rst_cnt", 32'(load_count), 32'd0);
    tick();

    // Boot fill of four words
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_address = 32'(i * 4); load_data = 32'hA000_0000 + 32'(i);
      mid();
      check("boot_we", 32'(mem_write_en), 32'd1);
      check("boot_addr", mem_address, 32'(i * 4));
      tick();
    end

    // Out-of-range boot write
    load_address = 32'h100; load_data = 32'hFFFF_FFFF;
    mid();
    check("oor_we", 32'(mem_write_en), 32'd0);
    check("oor_ready", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    mid();
    check("oor_err", 32'(load_error), 32'd1);
    check("oor_cnt", 32'(load_count), 32'd4);

    // load_done -> RUN
    load_done = 1'b1;
    tick();
    load_done = 1'b0; fetch_address = 32'h8;
    mid();
    check("run_state", 32'(dbg_state_o), 32'd1);
    check("run_cnt", 32'(load_count), 32'd4);
    check("run_fetch8", fetch_instruction, 32'hA000_0002);
    check("run_stall", 32'(fetch_stall), 32'd0);
    check("run_we", 32'(mem_write_en), 32'd0);
    tick();

    // Patch in a hazard stall slot
    load_valid = 1'b1; load_address = 32'h4; load_data = 32'hDEAD_BEEF;
    fetch_hold = 1'b1; fetch_address = 32'h4;
    mid();
    check("hold_ready", 32'(load_ready), 32'd1);
    check("hold_we", 32'(mem_write_en), 32'd1);
    check("hold_stall", 32'(fetch_stall), 32'd0);
    tick();
    load_valid = 1'b0; fetch_hold = 1'b0;
    mid();
    check("hold_fetch", fetch_instruction, 32'hDEAD_BEEF);
    check("hold_cnt", 32'(load_count), 32'd5);
    tick();

    // Unaligned patch lands on the containing word
    load_valid = 1'b1; load_address = 32'h13; load_data = 32'h0BAD_F00D; fetch_hold = 1'b1;
    tick();
    load_valid = 1'b0; fetch_hold = 1'b0; fetch_address = 32'h10;
    mid();
    check("unal_fetch", fetch_instruction, 32'h0BAD_F00D);
    tick();

    // Starvation: an interrupted wait restarts the counter
    load_valid = 1'b1; load_address = 32'hC; load_data = 32'h1234_5678; fetch_address = 32'h0;
    for (int c = 0; c < 4; c++) begin
      mid();
      check("pre_ready", 32'(load_ready), 32'd0);
      tick();
    end
    load_valid = 1'b0;
    tick();
    load_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      mid();
      check("wait_ready", 32'(load_ready), 32'd0);
      check("wait_stall", 32'(fetch_stall), 32'd0);
      check("wait_fetch", fetch_instruction, 32'hA000_0000);
      tick();
    end
    mid();
    check("steal_ready", 32'(load_ready), 32'd1);
    check("steal_stall", 32'(fetch_stall), 32'd1);
    check("steal_instr", fetch_instruction, 32'h0);
    check("steal_we", 32'(mem_write_en), 32'd1);
    check("steal_addr", mem_address, 32'hC);
    tick();
    load_valid = 1'b0; fetch_address = 32'hC;
    mid();
    check("steal_fetch", fetch_instruction, 32'h1234_5678);
    check("steal_stall2", 32'(fetch_stall), 32'd0);
    check("steal_cnt", 32'(load_count), 32'd7);

    // load_done in RUN is ignored
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    mid();
    check("done_run", 32'(dbg_state_o), 32'd1);
    tick();

    // Reset mid-write blocks the write and returns to BOOT
    reset = 1'b1; load_valid = 1'b1; fetch_hold = 1'b1;
    load_address = 32'h0; load_data = 32'h0000_0BAD;
    mid();
    check("rstw_we", 32'(mem_write_en), 32'd0);
    tick();
    reset = 1'b0; load_valid = 1'b0; fetch_hold = 1'b0;
    mid();
    check("rstw_state", 32'(dbg_state_o), 32'd0);
    check("rstw_stall", 32'(fetch_stall), 32'd1);
    check("rstw_cnt", 32'(load_count), 32'd0);
    check("rstw_err", 32'(load_error), 32'd0);
    tick();

    // Write and load_done in the same BOOT cycle
    load_valid = 1'b1; load_done = 1'b1; load_address = 32'h14; load_data = 32'h5555_AAAA;
    mid();
    check("wd_we", 32'(mem_write_en), 32'd1);
    tick();
    load_valid = 1'b0; load_done = 1'b0; fetch_address = 32'h14;
    mid();
    check("wd_state", 32'(dbg_state_o), 32'd1);
    check("wd_cnt", 32'(load_count), 32'd1);
    check("wd_fetch", fetch_instruction, 32'h5555_AAAA);
    tick();
    fetch_address = 32'h0;
    mid();
    check("wd_word0", fetch_instruction, 32'hA000_0000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
